shift_arb_ctrl: RTL

- Round-robin arbiter and sequencer that shares one 8-bit logical left barrel shifter among NUM_REQ requesters.
- Accepts shift requests over valid/ready handshakes and drives the shared shifter's data and select inputs from registered operands.
- Captures the shifter's combinational result and returns it, tagged with the requester ID, over a valid/ready response channel.
- Sits between client blocks and the single shifter instance. That instance connects externally through the shf_* ports.

---
 rtl/shift_arb_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/shift_arb_ctrl.sv
// Round-robin arbiter sharing one external 8-bit left barrel shifter; SHIFT_ARB_STATS_EN adds op_count.
// Latency: 2 edges from request accept to rsp_valid; accepts at most once every 3 cycles.
// Backpressure: response held until rsp_ready; no request is accepted while a response is pending.
module shift_arb_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ*3-1:0] req_amt,
    output logic [7:0]           shf_data,
    output logic [2:0]           shf_sel,
    input  logic [7:0]           shf_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [7:0]           rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] win_id;
    logic            win_vld;
    logic            accept;
    logic            rsp_done;

    // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                win_vld = 1'b1;
                win_id  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign accept   = (state == IDLE) && win_vld && rst_n;
    assign rsp_done = rsp_valid && rsp_ready;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = EXEC;
            EXEC:                  state_nxt = RESP;
            RESP:    if (rsp_done) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            grant_id  <= '0;
            shf_data  <= '0;
            shf_sel   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            // Shifter operands only move on accept so the shared shifter stays quiet otherwise.
            if (accept) begin
                shf_data <= req_data[int'(win_id)*8 +: 8];
                shf_sel  <= req_amt[int'(win_id)*3 +: 3];
                grant_id <= win_id;
                rr_ptr   <= ID_W'((int'(win_id) + 1) % NUM_REQ);
            end
            if (state == EXEC) begin
                rsp_data  <= shf_result;
                rsp_id    <= grant_id;
                rsp_valid <= 1'b1;
            end else if (rsp_done) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef SHIFT_ARB_STATS_EN
    logic [15:0] op_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q <= 16'h0000;
        end else if (rsp_done && (op_cnt_q != 16'hFFFF)) begin
            op_cnt_q <= op_cnt_q + 16'd1;
        end
    end

    assign op_count = op_cnt_q;
`else
    assign op_count = 16'h0000;
`endif

endmodule
